lcd_ctrl: RTL

Memory-mapped sequencer for the 11-bit character-LCD port, replacing the raw CPU-driven `lcd` register at 0xff0c. CPU stores are posted into a small command FIFO. An FSM then replays each entry as an HD44780-style write cycle with programmable setup, enable-pulse, hold and execution delays, so software no longer bit-bangs the enable line or busy-waits. It runs in the 62.5 MHz CPU clock domain, and the top level muxes its status word into `readdata`.

---
 rtl/lcd_ctrl_pkg.sv | 40 ++++
 rtl/lcd_cmd_fifo.sv | 54 +++++
 rtl/lcd_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the character-LCD command sequencer.
// Bit positions for the lcd port and status word, plus the long-running opcodes.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] db;
  } lcd_cmd_t;

  localparam int LCD_RS = 10;
  localparam int LCD_RW = 9;
  localparam int LCD_E  = 8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF  = 2;
  localparam int STAT_CNT  = 4;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  // Clear and return-home need the long execution wait on the panel.
  function automatic logic is_long_cmd(input lcd_cmd_t c);
    return !c.rs && ((c.db == OP_CLEAR) || (c.db == OP_HOME) || (c.db == OP_HOME_ALT));
  endfunction

  function automatic logic [2:0] sat3(input int n);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO holding posted {RS, DB} LCD commands.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module lcd_cmd_fifo
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  lcd_cmd_t                 din,
  input  logic                     pop,
  output lcd_cmd_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  lcd_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// Memory-mapped HD44780 write sequencer: CPU stores are queued and replayed as
// timed setup / enable-pulse / hold / execute cycles on the 11-bit lcd port.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int T_SETUP = 4,
  parameter int T_EPW   = 16,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2500,
  parameter int T_LONG  = 102500,
  parameter int CW      = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] status,
  output logic [10:0] lcd
);

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EPW   = CW'(T_EPW - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG - 1);

  state_t                  state;
  state_t                  state_d;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_d;
  lcd_cmd_t                cur;
  logic                    overflow;

  logic                    store;
  logic                    push_req;
  logic                    ovf_clr;
  logic                    pop;
  lcd_cmd_t                fifo_dout;
  lcd_cmd_t                fifo_din;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    unused_wdata;

  // Handshake: a store is posted with no back-pressure. The FSM pops the FIFO
  // head only from IDLE while the FIFO is non-empty; a push that meets a full
  // FIFO without a same-cycle pop is dropped and flagged in the sticky overflow bit.
  assign store        = cs && memwrite;
  assign ovf_clr      = store && writedata[31];
  assign push_req     = store && !writedata[31];
  assign fifo_din     = '{rs: writedata[8], db: writedata[7:0]};
  assign unused_wdata = ^writedata[30:9];

  lcd_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Each timed state loads (N-1) on entry and leaves when the counter hits zero.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_d = ST_PULSE;
          cnt_d   = LD_EPW;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_d = ST_WAIT;
          cnt_d   = is_long_cmd(cur) ? LD_LONG : LD_EXEC;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) cur <= fifo_dout;
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // RS/DB stay on the bus between commands; only E depends on the state.
  always_comb begin
    lcd         = '0;
    lcd[7:0]    = cur.db;
    lcd[LCD_E]  = (state == ST_PULSE);
    lcd[LCD_RW] = 1'b0;
    lcd[LCD_RS] = cur.rs;
  end

  always_comb begin
    status                     = '0;
    status[STAT_CNT +: 3]      = sat3(int'(fifo_count));
    status[STAT_OVF]           = overflow;
    status[STAT_FULL]          = fifo_full;
    status[STAT_BUSY]          = (state != ST_IDLE) || !fifo_empty;
  end

endmodule
